serial_pattern_source: RTL and testbench
========================================

# serial_pattern_source

Upstream stimulus stage for the serial sequence detector: latches a parallel bit pattern and shifts it out MSB-first as the detector's single-bit `w` input, one bit per programmable number of clock cycles. Provides start/abort control, a one-shot or looping mode, and busy/done status for LEDs. It runs on the same clock and reset as the detector. Its `w_out` wires directly to the detector's `w`.

## Interface
- `WIDTH`, 8: maximum pattern length in bits
- `LEN_W`, 4: width of `len` and `bit_idx`; must satisfy 2^LEN_W > WIDTH
- `DIV`, 1: clock cycles each bit is held; legal range ≥ 1
- `CNT_W`, 26: width of the hold counter; must hold DIV-1
- `clock`  in  1  system clock; all state changes on the rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  level input; only its rising edge starts a transfer
- `abort`  in  1  synchronous, level-sensitive cancel
- `loop`  in  1  sampled at the end of each pass; 1 restarts the pattern
- `pattern`  in  WIDTH  bits to send, MSB first; latched on start
- `len`  in  LEN_W  number of bits to send; 0 or >WIDTH means WIDTH; latched on start
- `w_out`  out  1  serial bit to the detector
- `bit_valid`  out  1  one-cycle strobe, high in the first cycle of each new bit
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle strobe after a non-looping pass completes
- `bit_idx`  out  LEN_W  index of the bit currently on `w_out` (0 = MSB)

## Operation
- States: IDLE and SHIFT. Edge detect: `start_q` registers `start`; `start_pulse = start & ~start_q`.
- IDLE, on `start_pulse` with `abort`=0:
  - latch `pattern` into shift register and a reload copy; latch effective length `L`
  - go to SHIFT; `w_out`←`pattern[WIDTH-1]`, `bit_valid`←1, `busy`←1, `bit_idx`←0, hold counter←0
- SHIFT, hold counter < DIV-1: increment; outputs hold; `bit_valid`←0.
- SHIFT, hold counter = DIV-1 (bit period ends): counter←0, then:
  - `bit_idx` < L-1: shift left, present next bit, `bit_valid`←1, `bit_idx`+1
  - last bit and `loop`=1: reload from latched copy (not the live `pattern`), `w_out`←copy MSB, `bit_valid`←1, `bit_idx`←0, no `done`
  - last bit and `loop`=0: go to IDLE; `w_out`←0, `busy`←0, `bit_idx`←0, `done`←1 for one cycle
- `abort`=1 in any state has priority over everything else. Next edge: IDLE, `w_out`=0, `busy`=0, `bit_idx`=0, `bit_valid`=0, no `done`.
- `start_pulse` while in SHIFT is ignored; `start_q` still tracks `start`.
- Changes to `pattern`, `len` or `DIV` inputs during SHIFT have no effect.
- In IDLE, `w_out` stays 0, so the detector sees zeros between transfers.

## Timing
- Reset: state IDLE, `w_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `bit_idx`=0, counters 0, `start_q`=0.
- Reset is asynchronous and may occur mid-transfer. The transfer is discarded with no `done`. A `start` level that stays high through reset release counts as a rising edge.
- Latency: `start_pulse` sampled at edge k → first bit valid after edge k.
- Bit i is valid after edges k+i·DIV through k+(i+1)·DIV-1.
- `busy` is high for exactly L·DIV cycles. `done` is high in the single cycle after edge k+L·DIV.
- DIV=1: a new bit and `bit_valid` every cycle.
- L=1: one bit, then `done` (or a repeat of the same bit when looping).
- Starting again directly from `done` is legal; the earliest new `start_pulse` is sampled on the edge that ends `done`.

## Test plan
- DIV=1, `pattern`=8'b1101_0000, `len`=4, single start pulse → `w_out` 1,1,0,1 in cycles k+1..k+4; `bit_valid` high on all four; `busy` high for 4 cycles; `done`=1 in cycle k+5; `w_out`=0 afterwards.
- DIV=3, `pattern`=8'hA5, `len`=0 (treated as 8) → each bit of 1010_0101 held 3 cycles; `bit_valid` high once per 3 cycles; `bit_idx` 0..7; `busy` high for 24 cycles; then `done`.
- `loop`=1, `len`=3, `pattern`=8'b1100_0000, DIV=1 → repeating 1,1,0,1,1,0…, no `done`. Change `pattern` mid-run → no effect. Drop `loop` → one `done` after the current pass.
- Assert `abort` at `bit_idx`=2 → next cycle `busy`=0, `w_out`=0, `bit_idx`=0, no `done`.
- Hold `start` high for 10 cycles, then pulse it again while busy → exactly one transfer; the second pulse is ignored.
- Pulse `resetn` low mid-transfer, asynchronously between edges → all outputs 0 immediately; after release, IDLE until the next `start` rising edge.

Source files
------------

// File: rtl/serial_pattern_source.sv
// Serial pattern source: latches a parallel pattern on a start edge and shifts it out MSB-first,
// holding each bit for DIV clocks, with one-shot or looping passes and busy/done status.
module serial_pattern_source #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned DIV   = 1,
    parameter int unsigned CNT_W = 26
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             w_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_idx
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DIV - 1);
    localparam logic [LEN_W-1:0] LenWidth = LEN_W'(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               w_q, w_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_q;
    logic               start_pulse;
    logic [LEN_W-1:0]   len_eff;
    logic [WIDTH-1:0]   sh_shl;
    logic               last_bit;

    assign start_pulse = start & ~start_q;
    // A length of zero or beyond the register width means "send the whole register".
    assign len_eff     = ((len == '0) || (len > LenWidth)) ? LenWidth : len;
    assign sh_shl      = sh_q << 1;
    assign last_bit    = (idx_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        w_d     = w_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = StIdle;
            w_d     = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_pulse) begin
                        state_d = StShift;
                        sh_d    = pattern;
                        pat_d   = pattern;
                        len_d   = len_eff;
                        cnt_d   = '0;
                        idx_d   = '0;
                        w_d     = pattern[WIDTH-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (!last_bit) begin
                            sh_d    = sh_shl;
                            w_d     = sh_shl[WIDTH-1];
                            valid_d = 1'b1;
                            idx_d   = idx_q + LEN_W'(1);
                        end else if (loop) begin
                            // Reload from the latched copy so live pattern edits never leak in.
                            sh_d    = pat_q;
                            w_d     = pat_q[WIDTH-1];
                            valid_d = 1'b1;
                            idx_d   = '0;
                        end else begin
                            state_d = StIdle;
                            w_d     = 1'b0;
                            busy_d  = 1'b0;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            sh_q    <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start;
        end
    end

    assign w_out     = w_q;
    assign bit_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_idx   = idx_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: two instances (DIV=1 and DIV=3) on shared stimulus, each
// compared every cycle against an elapsed-time reference model.
module tb_serial_pattern_source;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       loop    = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len     = '0;

    logic [1:0] w_v, valid_v, busy_v, done_v;
    logic [3:0] idx0, idx1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Reference state: elapsed cycles within the current pass, per instance.
    int         div_of [2] = '{1, 3};
    bit         m_active [2];
    int         m_e [2];
    logic [7:0] m_pat [2];
    int         m_len [2];
    bit         m_done [2];
    bit         m_sprev;

    always #5 clock = ~clock;

    serial_pattern_source #(.WIDTH(8), .LEN_W(4), .DIV(1), .CNT_W(26)) u_div1 (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort), .loop(loop),
        .pattern(pattern), .len(len), .w_out(w_v[0]), .bit_valid(valid_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .bit_idx(idx0)
    );

    serial_pattern_source #(.WIDTH(8), .LEN_W(4), .DIV(3), .CNT_W(26)) u_div3 (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort), .loop(loop),
        .pattern(pattern), .len(len), .w_out(w_v[1]), .bit_valid(valid_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .bit_idx(idx1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_active[n] = 1'b0;
            m_done[n]   = 1'b0;
            m_e[n]      = 0;
        end
        m_sprev = 1'b0;
    endtask

    task automatic model_step();
        bit sp;
        sp = start && !m_sprev;
        for (int n = 0; n < 2; n++) begin
            m_done[n] = 1'b0;
            if (!resetn || abort) begin
                m_active[n] = 1'b0;
            end else if (!m_active[n]) begin
                if (sp) begin
                    m_active[n] = 1'b1;
                    m_e[n]      = 0;
                    m_pat[n]    = pattern;
                    m_len[n]    = (len == 0 || len > 8) ? 8 : int'(len);
                end
            end else if (m_e[n] == m_len[n] * div_of[n] - 1) begin
                if (loop) begin
                    m_e[n] = 0;
                end else begin
                    m_active[n] = 1'b0;
                    m_done[n]   = 1'b1;
                end
            end else begin
                m_e[n]++;
            end
        end
        m_sprev = resetn ? start : 1'b0;
    endtask

    task automatic check_outputs();
        int   idx;
        logic exp_w;
        logic [3:0] got_idx;
        for (int n = 0; n < 2; n++) begin
            idx     = m_active[n] ? m_e[n] / div_of[n] : 0;
            exp_w   = m_active[n] ? m_pat[n][7 - idx] : 1'b0;
            got_idx = (n == 0) ? idx0 : idx1;
            check($sformatf("w_out[%0d]", n), 32'(w_v[n]), 32'(exp_w));
            check($sformatf("bit_valid[%0d]", n), 32'(valid_v[n]),
                  32'(m_active[n] && (m_e[n] % div_of[n] == 0)));
            check($sformatf("busy[%0d]", n), 32'(busy_v[n]), 32'(m_active[n]));
            check($sformatf("done[%0d]", n), 32'(done_v[n]), 32'(m_done[n]));
            check($sformatf("bit_idx[%0d]", n), 32'(got_idx), 32'(idx));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
        if (done_v[1]) done_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reset lands between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async.busy", 32'(busy_v), 32'd0);
        check("rst_async.w_out", 32'(w_v), 32'd0);
        check("rst_async.bit_valid", 32'(valid_v), 32'd0);
        check("rst_async.done", 32'(done_v), 32'd0);
        check("rst_async.bit_idx", 32'({idx1, idx0}), 32'd0);
        model_reset();
        run(2);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        int guard;
        model_reset();

        run(2);
        #2;
        resetn = 1'b1;
        run(2);

        // 4-bit one-shot: 1,1,0,1
        pattern = 8'b1101_0000;
        len     = 4'd4;
        pulse_start();
        run(16);

        // len 0 means full width
        pattern = 8'hA5;
        len     = 4'd0;
        pulse_start();
        run(30);

        // Looping 3-bit pass; live pattern edits must not leak into the reload.
        loop    = 1'b1;
        pattern = 8'b1100_0000;
        len     = 4'd3;
        pulse_start();
        run(8);
        pattern = 8'hFF;
        run(10);
        loop = 1'b0;
        run(12);

        // Abort while the DIV=3 instance is on bit 2.
        pattern = 8'hB7;
        len     = 4'd8;
        pulse_start();
        guard = 0;
        while (!(m_active[1] && m_e[1] / 3 == 2) && guard < 20) begin
            tick();
            guard++;
        end
        check("abort_wait_timeout", 32'(guard < 20), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", 32'(busy_v[1]), 32'd0);
        check("abort.w_out", 32'(w_v[1]), 32'd0);
        check("abort.bit_idx", 32'(idx1), 32'd0);
        check("abort.done", 32'(done_v[1]), 32'd0);
        run(4);

        // Start held high, then re-pulsed while busy: one transfer on the DIV=3 instance.
        done_cnt = 0;
        start    = 1'b1;
        run(10);
        start = 1'b0;
        run(2);
        pulse_start();
        run(30);
        check("one_transfer.done_count", 32'(done_cnt), 32'd1);

        // Async reset mid-transfer, then idle until the next start edge.
        pattern = 8'hF0;
        len     = 4'd6;
        pulse_start();
        run(4);
        async_reset();
        run(6);
        check("post_reset.idle", 32'(busy_v), 32'd0);

        // Start held through reset release counts as a rising edge.
        start = 1'b1;
        async_reset();
        run(3);
        start = 1'b0;
        run(30);

        // Randomised traffic, including live input changes and occasional aborts.
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) start = ~start;
            abort   = ($urandom_range(0, 39) == 0);
            loop    = ($urandom_range(0, 2) != 0);
            pattern = 8'($urandom);
            len     = 4'($urandom_range(0, 15));
            tick();
        end
        loop  = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
